// File: rtl/lc3b_types.sv
//------------------------------------------------------------------------------
// Module   : lc3b_types
// Brief    : Shared cache-side types and default sizes for the victim buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lc3b_types;

    localparam int VIC_TAG_WIDTH  = 12;
    localparam int VIC_LINE_WIDTH = 256;
    localparam int VIC_DEPTH      = 4;

    typedef logic [VIC_TAG_WIDTH-1:0]  lc3b_vic_tag;
    typedef logic [VIC_LINE_WIDTH-1:0] lc3b_vic_line;

endpackage

`default_nettype wire

// File: rtl/victim_buffer_if.sv
//------------------------------------------------------------------------------
// Module   : victim_buffer_if
// Brief    : Insert, lookup/take and writeback signals of the victim buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface victim_buffer_if
    import lc3b_types::*;
#(
    parameter int WIDTH     = VIC_LINE_WIDTH,
    parameter int TAG_WIDTH = VIC_TAG_WIDTH,
    parameter int DEPTH     = VIC_DEPTH
) ();

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                 ins_valid;
    logic                 ins_ready;
    logic [TAG_WIDTH-1:0] ins_tag;
    logic [WIDTH-1:0]     ins_data;
    logic                 ins_dirty;
    logic [TAG_WIDTH-1:0] lk_tag;
    logic                 lk_hit;
    logic [WIDTH-1:0]     lk_data;
    logic                 lk_dirty;
    logic                 lk_take;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [TAG_WIDTH-1:0] wb_tag;
    logic [WIDTH-1:0]     wb_data;
    logic [CNT_W-1:0]     count;

    modport slave (
        input  ins_valid, ins_tag, ins_data, ins_dirty, lk_tag, lk_take, wb_ready,
        output ins_ready, lk_hit, lk_data, lk_dirty, wb_valid, wb_tag, wb_data, count
    );

    modport master (
        output ins_valid, ins_tag, ins_data, ins_dirty, lk_tag, lk_take, wb_ready,
        input  ins_ready, lk_hit, lk_data, lk_dirty, wb_valid, wb_tag, wb_data, count
    );

endinterface

`default_nettype wire

// File: rtl/victim_buffer_alloc.sv
//------------------------------------------------------------------------------
// Module   : victim_buffer_alloc
// Brief    : Picks the insert target: tag match, else lowest free, else rr slot.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module victim_buffer_alloc
    import lc3b_types::*;
#(
    parameter int DEPTH = VIC_DEPTH,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid_i,
    input  logic [DEPTH-1:0] match_i,
    input  logic [IDXW-1:0]  rr_i,
    output logic [IDXW-1:0]  idx_o,
    output logic             displace_o,
    output logic             match_o
);

    always_comb begin
        idx_o      = rr_i;
        displace_o = 1'b1;
        match_o    = |match_i;
        if (match_o) begin
            displace_o = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (match_i[i]) idx_o = IDXW'(i);
            end
        end else begin
            // Descending scan so the lowest free index is the last one written.
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (!valid_i[i]) begin
                    idx_o      = IDXW'(i);
                    displace_o = 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/victim_buffer.sv
//------------------------------------------------------------------------------
// Module   : victim_buffer
// Brief    : Fully associative L1 victim buffer with take and dirty writeback.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module victim_buffer
    import lc3b_types::*;
#(
    parameter int WIDTH     = VIC_LINE_WIDTH,
    parameter int TAG_WIDTH = VIC_TAG_WIDTH,
    parameter int DEPTH     = VIC_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    victim_buffer_if.slave bus
);

    localparam int IDXW  = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_WIDTH-1:0] tag_q  [DEPTH];
    logic [WIDTH-1:0]     data_q [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d, dirty_q, dirty_d;
    logic [DEPTH-1:0]     ins_match, lk_match;
    logic [IDXW-1:0]      rr_q, rr_d, lk_idx, tgt_idx;
    logic                 tgt_displace, tgt_match, taken_tgt;
    logic                 ins_fire, take;
    logic                 wb_valid_q, wb_valid_d;
    logic [TAG_WIDTH-1:0] wb_tag_q, wb_tag_d;
    logic [WIDTH-1:0]     wb_data_q, wb_data_d, lk_data;
    logic [CNT_W-1:0]     count_q, count_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign ins_match[i] = valid_q[i] && (tag_q[i] == bus.ins_tag);
        assign lk_match[i]  = valid_q[i] && (tag_q[i] == bus.lk_tag);
    end

    always_comb begin
        lk_idx  = '0;
        lk_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (lk_match[i]) lk_idx = IDXW'(i);
            lk_data = lk_data | ({WIDTH{lk_match[i]}} & data_q[i]);
        end
    end

    victim_buffer_alloc #(.DEPTH(DEPTH), .IDXW(IDXW)) u_alloc (
        .valid_i    (valid_q),
        .match_i    (ins_match),
        .rr_i       (rr_q),
        .idx_o      (tgt_idx),
        .displace_o (tgt_displace),
        .match_o    (tgt_match)
    );

    assign ins_fire  = bus.ins_valid && !wb_valid_q;
    assign take      = bus.lk_take && (|lk_match);
    assign taken_tgt = take && (lk_idx == tgt_idx);

    always_comb begin
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        rr_d       = rr_q;
        wb_valid_d = wb_valid_q;
        wb_tag_d   = wb_tag_q;
        wb_data_d  = wb_data_q;
        count_d    = '0;
        if (wb_valid_q && bus.wb_ready) wb_valid_d = 1'b0;
        if (take) begin
            valid_d[lk_idx] = 1'b0;
            dirty_d[lk_idx] = 1'b0;
        end
        if (ins_fire) begin
            valid_d[tgt_idx] = 1'b1;
            // A line being taken back to L1 this cycle carries no old dirty state.
            if (tgt_match && !taken_tgt) dirty_d[tgt_idx] = dirty_q[tgt_idx] | bus.ins_dirty;
            else                         dirty_d[tgt_idx] = bus.ins_dirty;
            if (tgt_displace) begin
                rr_d = rr_q + 1'b1;
                if (dirty_q[tgt_idx] && !taken_tgt) begin
                    wb_valid_d = 1'b1;
                    wb_tag_d   = tag_q[tgt_idx];
                    wb_data_d  = data_q[tgt_idx];
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            rr_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            rr_q       <= rr_d;
            wb_valid_q <= wb_valid_d;
            wb_tag_q   <= wb_tag_d;
            wb_data_q  <= wb_data_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ins_fire) begin
            tag_q[tgt_idx]  <= bus.ins_tag;
            data_q[tgt_idx] <= bus.ins_data;
        end
    end

    assign bus.ins_ready = !wb_valid_q;
    assign bus.lk_hit    = |lk_match;
    assign bus.lk_data   = lk_data;
    assign bus.lk_dirty  = |(lk_match & dirty_q);
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_tag    = wb_tag_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.count     = count_q;

endmodule

`default_nettype wire
